// File: rtl/h80bus_initiator.sv
// h80 system bus initiator: turns one valid/ready request into a single ce_n-framed
// bus access with responder wait-state extension and a timeout abort.
module h80bus_initiator #(
    parameter int unsigned BUS_ADDR_WIDTH = 16,
    parameter int unsigned BUS_CMD_WIDTH  = 3,
    parameter int unsigned BUS_DATA_WIDTH = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [BUS_CMD_WIDTH-1:0] bus_cmd_read_b  = BUS_CMD_WIDTH'(1),
    parameter logic [BUS_CMD_WIDTH-1:0] bus_cmd_write_b = BUS_CMD_WIDTH'(5),
    parameter logic [BUS_CMD_WIDTH-1:0] bus_cmd_write_w = BUS_CMD_WIDTH'(6)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [BUS_ADDR_WIDTH-1:0] req_addr,
    input  logic [BUS_CMD_WIDTH-1:0]  req_cmd,
    input  logic [BUS_DATA_WIDTH-1:0] req_wdata,
    output logic                      resp_valid,
    output logic [BUS_DATA_WIDTH-1:0] resp_rdata,
    output logic                      resp_err,
    output logic                      bus_ce_n,
    output logic [BUS_ADDR_WIDTH-1:0] bus_addr,
    output logic [BUS_CMD_WIDTH-1:0]  bus_cmd,
    inout  wire  [BUS_DATA_WIDTH-1:0] bus_data,
    input  logic                      bus_wait_n
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WAIT,
        ST_TURN
    } state_t;

    state_t                    state_q, state_d;
    logic [BUS_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      ce_n_d;
    logic [BUS_ADDR_WIDTH-1:0] addr_d;
    logic [BUS_CMD_WIDTH-1:0]  cmd_d;
    logic                      resp_valid_d;
    logic [BUS_DATA_WIDTH-1:0] rdata_d;
    logic                      err_d;
    logic                      cmd_is_write;
    logic [BUS_DATA_WIDTH-1:0] read_word;

    assign cmd_is_write = (bus_cmd == bus_cmd_write_b) || (bus_cmd == bus_cmd_write_w);
    assign req_ready    = (state_q == ST_IDLE);

    // Only the initiator's own registered ce_n/cmd gate the driver, so the
    // data bus is released on the same edge that raises ce_n.
    assign bus_data = (!bus_ce_n && cmd_is_write) ? wdata_q : {BUS_DATA_WIDTH{1'bz}};

    assign read_word = (bus_cmd == bus_cmd_read_b)
                     ? {{(BUS_DATA_WIDTH-8){1'b0}}, bus_data[7:0]}
                     : bus_data;

    always_comb begin
        state_d      = state_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        ce_n_d       = bus_ce_n;
        addr_d       = bus_addr;
        cmd_d        = bus_cmd;
        resp_valid_d = 1'b0;
        rdata_d      = resp_rdata;
        err_d        = resp_err;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = ST_ADDR;
                    ce_n_d  = 1'b0;
                    addr_d  = req_addr;
                    cmd_d   = req_cmd;
                    wdata_d = req_wdata;
                end
            end
            ST_ADDR: state_d = ST_WAIT;
            ST_WAIT: begin
                if (bus_wait_n) begin
                    state_d      = ST_TURN;
                    ce_n_d       = 1'b1;
                    resp_valid_d = 1'b1;
                    err_d        = 1'b0;
                    rdata_d      = cmd_is_write ? '0 : read_word;
                end else if (cnt_q == CNT_LAST) begin
                    state_d      = ST_TURN;
                    ce_n_d       = 1'b1;
                    resp_valid_d = 1'b1;
                    err_d        = 1'b1;
                    rdata_d      = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_TURN: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            wdata_q    <= '0;
            cnt_q      <= '0;
            bus_ce_n   <= 1'b1;
            bus_addr   <= '0;
            bus_cmd    <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            bus_ce_n   <= ce_n_d;
            bus_addr   <= addr_d;
            bus_cmd    <= cmd_d;
            resp_valid <= resp_valid_d;
            resp_rdata <= rdata_d;
            resp_err   <= err_d;
        end
    end

endmodule

// File: tb/tb_h80bus_initiator.sv
// Self-checking bench for h80bus_initiator: directed vector table, corner-case
// sequences and randomized accesses against a transaction-level reference model.
module tb_h80bus_initiator;

    localparam int unsigned TO = 4;
    localparam logic [2:0] C_RB = 3'd1;
    localparam logic [2:0] C_RW = 3'd2;
    localparam logic [2:0] C_WB = 3'd5;
    localparam logic [2:0] C_WW = 3'd6;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_addr;
    logic [2:0]  req_cmd;
    logic [15:0] req_wdata;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic        resp_err;
    logic        bus_ce_n;
    logic [15:0] bus_addr;
    logic [2:0]  bus_cmd;
    wire  [15:0] bus_data;
    logic        bus_wait_n;
    logic [15:0] rbus;

    int n_checks = 0;
    int n_errors = 0;

    function automatic logic is_wr(input logic [2:0] c);
        return (c == C_WB) || (c == C_WW);
    endfunction

    // Responder: returns rbus on reads, pulls the bus to zero while ce_n is high
    // so any stray initiator drive shows up as a non-zero value.
    assign bus_data = (bus_ce_n || !is_wr(bus_cmd)) ? (bus_ce_n ? 16'h0000 : rbus) : 16'hzzzz;

    always #5 clk = ~clk;

    h80bus_initiator #(
        .BUS_ADDR_WIDTH (16),
        .BUS_CMD_WIDTH  (3),
        .BUS_DATA_WIDTH (16),
        .TIMEOUT_CYCLES (TO),
        .bus_cmd_read_b (C_RB),
        .bus_cmd_write_b(C_WB),
        .bus_cmd_write_w(C_WW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_cmd   (req_cmd),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err),
        .bus_ce_n  (bus_ce_n),
        .bus_addr  (bus_addr),
        .bus_cmd   (bus_cmd),
        .bus_data  (bus_data),
        .bus_wait_n(bus_wait_n)
    );

    typedef struct {
        string       name;
        logic [2:0]  cmd;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rb;
        int unsigned waits;
        logic [15:0] exp_rdata;
        logic        exp_err;
        int unsigned exp_low;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Whole-transaction reference: outcome follows from how many wait-low cycles
    // the responder inserts versus the timeout limit.
    function automatic void ref_model(input logic [2:0] cmd, input logic [15:0] rb,
                                      input int unsigned waits, output logic [15:0] rd,
                                      output logic err, output int unsigned low);
        err = (waits >= TO);
        low = 1 + (err ? TO : waits + 1);
        if (err || is_wr(cmd)) rd = 16'h0000;
        else if (cmd == C_RB)  rd = {8'h00, rb[7:0]};
        else                   rd = rb;
    endfunction

    task automatic run_access(input string name, input logic [2:0] cmd, input logic [15:0] addr,
                              input logic [15:0] wdata, input logic [15:0] rb,
                              input int unsigned waits, input logic [15:0] exp_rdata,
                              input logic exp_err, input int unsigned exp_low);
        int unsigned low;
        int          resp_cyc;
        bit          addr_ok;
        bit          data_ok;
        bit          idle_ok;
        logic [15:0] got_rdata;
        logic        got_err;
        @(negedge clk);
        check({name, "/ready"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_addr   = addr;
        req_cmd    = cmd;
        req_wdata  = wdata;
        rbus       = rb;
        bus_wait_n = 1'b1;
        low = 0; resp_cyc = -1; addr_ok = 1; data_ok = 1; idle_ok = 0;
        got_rdata = 16'hxxxx; got_err = 1'bx;
        for (int cyc = 0; cyc < 40 && resp_cyc < 0; cyc++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (!bus_ce_n) begin
                low++;
                if (bus_addr !== addr || bus_cmd !== cmd) addr_ok = 0;
                if (is_wr(cmd) && bus_data !== wdata) data_ok = 0;
                bus_wait_n = (low >= 2) && (low - 2 >= waits);
            end
            if (resp_valid === 1'b1) begin
                resp_cyc  = cyc;
                got_rdata = resp_rdata;
                got_err   = resp_err;
                idle_ok   = (bus_ce_n === 1'b1) && (bus_data === 16'h0000);
            end
        end
        bus_wait_n = 1'b1;
        check({name, "/resp_cycle"}, 32'(resp_cyc), 32'(exp_low));
        check({name, "/ce_low_cycles"}, 32'(low), 32'(exp_low));
        check({name, "/rdata"}, 32'(got_rdata), 32'(exp_rdata));
        check({name, "/err"}, 32'(got_err), 32'(exp_err));
        check({name, "/addr_cmd"}, 32'(addr_ok), 32'd1);
        check({name, "/wdata_on_bus"}, 32'(data_ok), 32'd1);
        check({name, "/turn_idle_bus"}, 32'(idle_ok), 32'd1);
        @(negedge clk);
        check({name, "/strobe_one_cycle"}, 32'(resp_valid), 32'd0);
        check({name, "/ready_after"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{"wr_b_nowait",  C_WB, 16'h0000, 16'h0041, 16'h0000, 0,  16'h0000, 1'b0, 2};
        vecs[1] = '{"rd_w_3wait",   C_RW, 16'h1234, 16'h0000, 16'hBEEF, 3,  16'hBEEF, 1'b0, 5};
        vecs[2] = '{"rd_b_zext",    C_RB, 16'h0010, 16'h0000, 16'hA55A, 0,  16'h005A, 1'b0, 2};
        vecs[3] = '{"rd_w_timeout", C_RW, 16'h2000, 16'h0000, 16'h1111, 50, 16'h0000, 1'b1, 5};
        vecs[4] = '{"wr_w_timeout", C_WW, 16'h3000, 16'hC3C3, 16'h0000, 4,  16'h0000, 1'b1, 5};
        vecs[5] = '{"rd_b_edge",    C_RB, 16'h4000, 16'h0000, 16'h12FF, 3,  16'h00FF, 1'b0, 5};
        vecs[6] = '{"unk_cmd_read", 3'd7, 16'h5000, 16'h9999, 16'h7E81, 1,  16'h7E81, 1'b0, 3};
        vecs[7] = '{"wr_w_2wait",   C_WW, 16'hFFFF, 16'h8001, 16'h0000, 2,  16'h0000, 1'b0, 4};

        reset_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_cmd = '0; req_wdata = '0;
        bus_wait_n = 1'b1; rbus = '0;
        repeat (3) @(negedge clk);
        check("reset/ce_n", 32'(bus_ce_n), 32'd1);
        check("reset/addr", 32'(bus_addr), 32'd0);
        check("reset/cmd", 32'(bus_cmd), 32'd0);
        check("reset/ready", 32'(req_ready), 32'd1);
        check("reset/resp_valid", 32'(resp_valid), 32'd0);
        check("reset/rdata", 32'(resp_rdata), 32'd0);
        check("reset/err", 32'(resp_err), 32'd0);
        check("reset/bus_data", 32'(bus_data), 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++)
            run_access(vecs[i].name, vecs[i].cmd, vecs[i].addr, vecs[i].wdata, vecs[i].rb,
                       vecs[i].waits, vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_low);

        // Back-to-back: req_valid held high across three requests.
        begin
            int acc[$];
            int rsp[$];
            int low_cnt;
            bit drop;
            low_cnt = 0; drop = 0;
            @(negedge clk);
            req_valid = 1'b1; req_cmd = C_RW; req_addr = 16'h0100; rbus = 16'h1357;
            bus_wait_n = 1'b1;
            for (int i = 0; i < 16; i++) begin
                if (drop) begin
                    req_valid = 1'b0;
                    drop = 0;
                end
                if (resp_valid === 1'b1) rsp.push_back(i);
                if (bus_ce_n === 1'b0) low_cnt++;
                if (req_valid && req_ready === 1'b1) begin
                    acc.push_back(i);
                    if (acc.size() == 3) drop = 1;
                end
                @(negedge clk);
            end
            req_valid = 1'b0;
            check("b2b/accepts", 32'(acc.size()), 32'd3);
            check("b2b/resp_strobes", 32'(rsp.size()), 32'd3);
            check("b2b/ce_low_total", 32'(low_cnt), 32'd6);
            if (acc.size() == 3 && rsp.size() == 3) begin
                check("b2b/spacing1", 32'(acc[1] - acc[0]), 32'd4);
                check("b2b/spacing2", 32'(acc[2] - acc[1]), 32'd4);
                check("b2b/resp_lat", 32'(rsp[2] - acc[2]), 32'd3);
            end
        end

        // Reset during the WAIT phase of a write.
        begin
            int stray;
            stray = 0;
            @(negedge clk);
            req_valid = 1'b1; req_cmd = C_WW; req_addr = 16'h0ABC; req_wdata = 16'h1357;
            bus_wait_n = 1'b0;
            @(negedge clk);
            req_valid = 1'b0;
            @(negedge clk);
            @(negedge clk);
            check("rst_mid/in_access", 32'(bus_ce_n), 32'd0);
            check("rst_mid/wdata", 32'(bus_data), 32'h1357);
            reset_n = 1'b0;
            @(negedge clk);
            check("rst_mid/ce_n", 32'(bus_ce_n), 32'd1);
            check("rst_mid/bus_released", 32'(bus_data), 32'd0);
            check("rst_mid/resp_valid", 32'(resp_valid), 32'd0);
            check("rst_mid/ready", 32'(req_ready), 32'd1);
            reset_n = 1'b1; bus_wait_n = 1'b1;
            repeat (6) begin
                @(negedge clk);
                if (resp_valid !== 1'b0) stray++;
            end
            check("rst_mid/no_stray_resp", 32'(stray), 32'd0);
            run_access("after_reset", C_RW, 16'h0777, 16'h0000, 16'hBEEF, 3, 16'hBEEF, 1'b0, 5);
        end

        // Randomized accesses against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  cmd;
            logic [15:0] rb;
            logic [15:0] wd;
            int unsigned waits;
            logic [15:0] exp_rd;
            logic        exp_err;
            int unsigned exp_low;
            cmd   = 3'($urandom_range(0, 7));
            rb    = 16'($urandom);
            wd    = 16'($urandom_range(1, 16'hFFFF));
            waits = $urandom_range(0, TO + 2);
            ref_model(cmd, rb, waits, exp_rd, exp_err, exp_low);
            run_access($sformatf("rand%0d", i), cmd, 16'($urandom), wd, rb, waits,
                       exp_rd, exp_err, exp_low);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
